sys_exec: RTL and testbench

Execute-stage consumer of the `sys_ops` decoder bundle (`sys_ops.dst`). It implements the machine-mode CSR file, and executes CSR read-modify-write, `ecall`, `ebreak`, `mret` and `wfi`. It also takes the machine timer interrupt at instruction boundaries. Outputs are a registered writeback value and a pipeline redirect (trap entry or return), plus a combinational stall for `wfi`.

---
 rtl/sys_exec_if.sv | 15 +
 rtl/sys_exec.sv | 199 +++++++++++++++++++
 tb/tb_sys_exec.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_exec_if.sv
// Decoded system-op bundle handed from the decoder to the execute stage.
// Op bits are expected one-hot; sys_exec traps when more than one is set.
interface sys_ops;
    logic        csrrw;
    logic        csrrs;
    logic        csrrc;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        wfi;
    logic [11:0] csr_addr;

    modport src (output csrrw, csrrs, csrrc, ecall, ebreak, mret, wfi, csr_addr);
    modport dst (input  csrrw, csrrs, csrrc, ecall, ebreak, mret, wfi, csr_addr);
endinterface

// File: rtl/sys_exec.sv
// Execute stage for system ops: machine-mode CSR file, traps, mret, wfi and
// the machine timer interrupt, with registered writeback and redirect outputs.
module sys_exec #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    sys_ops.dst             ops,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic            timer_irq_i,
    output logic            stall_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            illegal_o
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [XLEN-1:0] LO2_MASK     = ~XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_MTI     = (XLEN'(1) << (XLEN - 1)) | XLEN'(7);

    typedef enum logic {RUN, WFI} state_t;

    state_t          state;
    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_mtie;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mcycle_q;

    logic [6:0]      op_vec;
    logic            multi_op;
    logic            is_csr;
    logic            wr_attempt;
    logic            csr_hit;
    logic            csr_ro;
    logic [XLEN-1:0] csr_rdata;
    logic [XLEN-1:0] csr_wdata;
    logic            illegal;
    logic            go;
    logic            irq_take;
    logic            wake;
    logic            accept;
    logic            enter_wfi;
    logic            trap;
    logic [XLEN-1:0] trap_cause;

    assign op_vec     = {ops.csrrw, ops.csrrs, ops.csrrc, ops.ecall, ops.ebreak, ops.mret, ops.wfi};
    assign multi_op   = |(op_vec & (op_vec - 7'd1));
    assign is_csr     = ops.csrrw | ops.csrrs | ops.csrrc;
    assign wr_attempt = ops.csrrw | ((ops.csrrs | ops.csrrc) & (|rs1_i));

    always_comb begin
        csr_rdata = '0;
        csr_hit   = 1'b1;
        csr_ro    = 1'b0;
        case (ops.csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[3] = mstatus_mie;
                csr_rdata[7] = mstatus_mpie;
            end
            CSR_MIE:      csr_rdata[7] = mie_mtie;
            CSR_MTVEC:    csr_rdata = mtvec_q & LO2_MASK;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q & LO2_MASK;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MIP: begin
                csr_rdata[7] = timer_irq_i;
                csr_ro       = 1'b1;
            end
            CSR_MCYCLE:   csr_rdata = mcycle_q;
            CSR_MHARTID:  csr_ro = 1'b1;
            default:      csr_hit = 1'b0;
        endcase
    end

    always_comb begin
        csr_wdata = rs1_i;
        if (ops.csrrs)
            csr_wdata = csr_rdata | rs1_i;
        else if (ops.csrrc)
            csr_wdata = csr_rdata & ~rs1_i;
    end

    assign illegal  = multi_op | (is_csr & (~csr_hit | (csr_ro & wr_attempt)));
    assign go       = valid_i & ~redirect_o & (state == RUN);
    assign irq_take = go & mstatus_mie & mie_mtie & timer_irq_i;
    assign wake     = mie_mtie & timer_irq_i;

    // wfi stalls on the cycle it is presented, so it never reaches accept;
    // it retires silently when the WFI state sees wake.
    always_comb begin
        stall_o = 1'b0;
        if (rst_n) begin
            if (state == WFI)
                stall_o = ~wake;
            else
                stall_o = go & ~irq_take & ~multi_op & ops.wfi;
        end
    end

    assign enter_wfi = (state == RUN) & stall_o;
    assign accept    = go & ~stall_o;
    assign trap      = irq_take | illegal | ops.ecall | ops.ebreak;

    always_comb begin
        trap_cause = CAUSE_EBREAK;
        if (irq_take)
            trap_cause = CAUSE_MTI;
        else if (illegal)
            trap_cause = CAUSE_ILLEGAL;
        else if (ops.ecall)
            trap_cause = CAUSE_ECALL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            mstatus_mie   <= 1'b0;
            mstatus_mpie  <= 1'b0;
            mie_mtie      <= 1'b0;
            mtvec_q       <= MTVEC_RST;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mcycle_q      <= '0;
            rd_we_o       <= 1'b0;
            rd_data_o     <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            illegal_o     <= 1'b0;
        end else begin
            rd_we_o    <= 1'b0;
            redirect_o <= 1'b0;
            illegal_o  <= 1'b0;
            mcycle_q   <= mcycle_q + XLEN'(1);

            if (enter_wfi)
                state <= WFI;
            else if ((state == WFI) && wake)
                state <= RUN;

            if (accept) begin
                if (trap) begin
                    mepc_q        <= pc_i;
                    mcause_q      <= trap_cause;
                    mstatus_mpie  <= mstatus_mie;
                    mstatus_mie   <= 1'b0;
                    redirect_o    <= 1'b1;
                    redirect_pc_o <= mtvec_q & LO2_MASK;
                    illegal_o     <= ~irq_take & illegal;
                end else if (ops.mret) begin
                    redirect_o    <= 1'b1;
                    redirect_pc_o <= mepc_q & LO2_MASK;
                    mstatus_mie   <= mstatus_mpie;
                    mstatus_mpie  <= 1'b1;
                end else if (is_csr) begin
                    rd_we_o   <= 1'b1;
                    rd_data_o <= csr_rdata;
                    if (wr_attempt) begin
                        case (ops.csr_addr)
                            CSR_MSTATUS: begin
                                mstatus_mie  <= csr_wdata[3];
                                mstatus_mpie <= csr_wdata[7];
                            end
                            CSR_MIE:      mie_mtie   <= csr_wdata[7];
                            CSR_MTVEC:    mtvec_q    <= csr_wdata;
                            CSR_MSCRATCH: mscratch_q <= csr_wdata;
                            CSR_MEPC:     mepc_q     <= csr_wdata;
                            CSR_MCAUSE:   mcause_q   <= csr_wdata;
                            CSR_MCYCLE:   mcycle_q   <= csr_wdata;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sys_exec.sv
// Directed bench for sys_exec: stimulus pushes expected responses into a
// scoreboard queue that a negedge monitor pops whenever the DUT responds.
module tb_sys_exec;
    localparam int XLEN = 64;

    localparam logic [6:0] OP_NONE   = 7'b0000000;
    localparam logic [6:0] OP_RW     = 7'b1000000;
    localparam logic [6:0] OP_RS     = 7'b0100000;
    localparam logic [6:0] OP_RC     = 7'b0010000;
    localparam logic [6:0] OP_ECALL  = 7'b0001000;
    localparam logic [6:0] OP_EBREAK = 7'b0000100;
    localparam logic [6:0] OP_MRET   = 7'b0000010;
    localparam logic [6:0] OP_WFI    = 7'b0000001;

    localparam logic [63:0] VEC = 64'h8000_0000;

    typedef struct packed {
        logic        we;
        logic [63:0] data;
        logic        redir;
        logic [63:0] pc;
        logic        ill;
        logic [15:0] id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_i = 1'b0;
    logic [XLEN-1:0] pc_i = '0;
    logic [XLEN-1:0] rs1_i = '0;
    logic            timer_irq_i = 1'b0;
    logic            stall_o;
    logic            rd_we_o;
    logic [XLEN-1:0] rd_data_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            illegal_o;

    int   n_checks = 0;
    int   n_fail = 0;
    int   txn_id = 0;
    int   stall_cnt;
    exp_t sb[$];

    sys_ops ops_bus();

    sys_exec #(.XLEN(XLEN), .MTVEC_RST('0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ops          (ops_bus),
        .valid_i      (valid_i),
        .pc_i         (pc_i),
        .rs1_i        (rs1_i),
        .timer_irq_i  (timer_irq_i),
        .stall_o      (stall_o),
        .rd_we_o      (rd_we_o),
        .rd_data_o    (rd_data_o),
        .redirect_o   (redirect_o),
        .redirect_pc_o(redirect_pc_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [6:0] v, input logic [11:0] a);
        {ops_bus.csrrw, ops_bus.csrrs, ops_bus.csrrc, ops_bus.ecall,
         ops_bus.ebreak, ops_bus.mret, ops_bus.wfi} = v;
        ops_bus.csr_addr = a;
    endtask

    task automatic issue(input logic [6:0] opv, input logic [11:0] addr, input logic [63:0] rs1,
                         input logic [63:0] pc, input exp_t e_in);
        exp_t e;
        e = e_in;
        e.id = 16'(txn_id);
        txn_id++;
        set_ops(opv, addr);
        rs1_i = rs1;
        pc_i = pc;
        valid_i = 1'b1;
        sb.push_back(e);
        #1 check($sformatf("txn%0d_stall", e.id), 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        set_ops(OP_NONE, 12'h0);
        @(posedge clk); #1;
    endtask

    task automatic csr(input logic [6:0] opv, input logic [11:0] addr, input logic [63:0] rs1,
                       input logic [63:0] exp_data);
        exp_t e;
        e = '0;
        e.we = 1'b1;
        e.data = exp_data;
        issue(opv, addr, rs1, 64'h0, e);
    endtask

    task automatic trap(input logic [6:0] opv, input logic [11:0] addr, input logic [63:0] rs1,
                        input logic [63:0] pc, input logic [63:0] tgt, input logic ill);
        exp_t e;
        e = '0;
        e.redir = 1'b1;
        e.pc = tgt;
        e.ill = ill;
        issue(opv, addr, rs1, pc, e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (rd_we_o || redirect_o || illegal_o)) begin
                check("we_redir_excl", 64'(rd_we_o & redirect_o), 64'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: rd_we=%b redirect=%b illegal=%b, required no output",
                             rd_we_o, redirect_o, illegal_o);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("txn%0d_rd_we", e.id), 64'(rd_we_o), 64'(e.we));
                    check($sformatf("txn%0d_redirect", e.id), 64'(redirect_o), 64'(e.redir));
                    check($sformatf("txn%0d_illegal", e.id), 64'(illegal_o), 64'(e.ill));
                    if (e.we)
                        check($sformatf("txn%0d_rd_data", e.id), rd_data_o, e.data);
                    if (e.redir)
                        check($sformatf("txn%0d_redirect_pc", e.id), redirect_pc_o, e.pc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // wfi presented while in reset: stall must stay low
        set_ops(OP_WFI, 12'h0);
        valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_rd_we", 64'(rd_we_o), 64'd0);
        check("rst_rd_data", rd_data_o, 64'd0);
        check("rst_redirect", 64'(redirect_o), 64'd0);
        check("rst_redirect_pc", redirect_pc_o, 64'd0);
        check("rst_illegal", 64'(illegal_o), 64'd0);
        valid_i = 1'b0;
        set_ops(OP_NONE, 12'h0);
        rst_n = 1'b1;

        csr(OP_RW, 12'h340, 64'hDEAD, 64'h0);
        csr(OP_RS, 12'h340, 64'h0F00, 64'hDEAD);
        csr(OP_RC, 12'h340, 64'h00AD, 64'hDFAD);
        csr(OP_RS, 12'h340, 64'h0, 64'hDF00);
        csr(OP_RW, 12'h305, 64'h8000_0003, 64'h0);
        csr(OP_RS, 12'h305, 64'h0, VEC);
        csr(OP_RW, 12'h300, '1, 64'h0);
        csr(OP_RW, 12'h300, 64'h8, 64'h88);

        trap(OP_ECALL, 12'h0, 64'h0, 64'h100, VEC, 1'b0);
        csr(OP_RS, 12'h341, 64'h0, 64'h100);
        csr(OP_RS, 12'h342, 64'h0, 64'd11);
        csr(OP_RS, 12'h300, 64'h0, 64'h80);
        trap(OP_MRET, 12'h0, 64'h0, 64'h104, 64'h100, 1'b0);
        csr(OP_RS, 12'h300, 64'h0, 64'h88);

        trap(OP_RW, 12'hF14, 64'h5, 64'h300, VEC, 1'b1);
        csr(OP_RS, 12'h342, 64'h0, 64'd2);
        csr(OP_RS, 12'h341, 64'h0, 64'h300);
        csr(OP_RS, 12'hF14, 64'h0, 64'h0);
        trap(OP_MRET, 12'h0, 64'h0, 64'h304, 64'h300, 1'b0);

        trap(OP_RS, 12'h7C0, 64'h0, 64'h500, VEC, 1'b1);
        trap(OP_MRET, 12'h0, 64'h0, 64'h504, 64'h500, 1'b0);
        trap(OP_RW | OP_ECALL, 12'h340, 64'h1234, 64'h400, VEC, 1'b1);
        csr(OP_RS, 12'h342, 64'h0, 64'd2);
        trap(OP_MRET, 12'h0, 64'h0, 64'h404, 64'h400, 1'b0);
        trap(OP_EBREAK, 12'h0, 64'h0, 64'h700, VEC, 1'b0);
        csr(OP_RS, 12'h342, 64'h0, 64'd3);
        trap(OP_MRET, 12'h0, 64'h0, 64'h704, 64'h700, 1'b0);

        csr(OP_RW, 12'h341, 64'h1237, 64'h700);
        csr(OP_RS, 12'h341, 64'h0, 64'h1234);
        csr(OP_RW, 12'h304, '1, 64'h0);
        csr(OP_RS, 12'h304, 64'h0, 64'h80);
        csr(OP_RS, 12'h344, 64'h0, 64'h0);

        // timer interrupt overrides a simultaneous csrrw
        timer_irq_i = 1'b1;
        trap(OP_RW, 12'h340, 64'h1111, 64'h200, VEC, 1'b0);
        timer_irq_i = 1'b0;
        csr(OP_RS, 12'h340, 64'h0, 64'hDF00);
        csr(OP_RS, 12'h342, 64'h0, 64'h8000_0000_0000_0007);
        csr(OP_RS, 12'h341, 64'h0, 64'h200);
        csr(OP_RS, 12'h300, 64'h0, 64'h80);

        // wfi with MIE=0, MTIE=1; irq arrives after six stalled cycles
        set_ops(OP_WFI, 12'h0);
        pc_i = 64'h600;
        valid_i = 1'b1;
        stall_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1 if (stall_o) stall_cnt++;
            @(posedge clk); #1;
        end
        timer_irq_i = 1'b1;
        #1 check("wfi_wake_stall", 64'(stall_o), 64'd0);
        check("wfi_stall_cycles", 64'(stall_cnt), 64'd6);
        @(posedge clk); #1;
        valid_i = 1'b0;
        set_ops(OP_NONE, 12'h0);
        timer_irq_i = 1'b0;
        @(posedge clk); #1;

        timer_irq_i = 1'b1;
        csr(OP_RS, 12'h344, 64'h0, 64'h80);
        timer_irq_i = 1'b0;

        // reset asserted while parked in WFI
        set_ops(OP_WFI, 12'h0);
        valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("wfi_hold_stall", 64'(stall_o), 64'd1);
        rst_n = 1'b0;
        #1 check("wfi_reset_stall", 64'(stall_o), 64'd0);
        valid_i = 1'b0;
        set_ops(OP_NONE, 12'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        csr(OP_RS, 12'hB00, 64'h0, 64'd0);
        csr(OP_RW, 12'hB00, 64'd100, 64'd2);
        csr(OP_RS, 12'hB00, 64'h0, 64'd101);
        csr(OP_RS, 12'h305, 64'h0, 64'h0);
        csr(OP_RS, 12'h300, 64'h0, 64'h0);

        repeat (4) @(posedge clk);
        #1 check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
